// File: rtl/sumsub_fa.sv
// 1-bit full adder cell; one link of the ripple-carry chain in sumsub_4.
module sumsub_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and majority carry.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/sumsub_4.sv
// 4-bit two's-complement adder/subtractor with a registered result and carry.
// Subtraction is a + ~b + 1 on the same ripple chain, so c_out=1 means
// no borrow when subtracting and unsigned overflow when adding.
module sumsub_4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    // c_in is reserved and deliberately kept out of the datapath.
    logic unused_c_in;
    assign unused_c_in = c_in;

    // Conditional inversion of b; sub doubles as the carry into bit 0.
    always_comb begin
        bx       = b ^ {WIDTH{sub}};
        carry[0] = sub;
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            sumsub_fa u_fa (
                .a  (a[i]),
                .b  (bx[i]),
                .ci (carry[i]),
                .s  (sum[i]),
                .co (carry[i+1])
            );
        end
    endgenerate

    // Output register; asynchronous active-low reset clears result and carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s     <= '0;
            c_out <= 1'b0;
        end else begin
            s     <= sum;
            c_out <= carry[WIDTH];
        end
    end

endmodule

// File: tb/tb_sumsub_4.sv
// Self-checking bench for sumsub_4: directed table, corner sequences,
// exhaustive sweep and random stimulus against an arithmetic reference.
module tb_sumsub_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a, b;
    logic       sub, c_in;
    logic [3:0] s;
    logic       c_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic       cin;
        logic [3:0] s_exp;
        logic       c_exp;
    } vec_t;

    vec_t vecs[7];

    sumsub_4 #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .c_in  (c_in),
        .s     (s),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned arithmetic on the operand values.
    task automatic model(input logic [3:0] ma, input logic [3:0] mb, input logic msub,
                         output logic [3:0] ms, output logic mc);
        int r;
        if (!msub) begin
            r  = int'(ma) + int'(mb);
            ms = 4'(r % 16);
            mc = (r > 15);
        end else begin
            r  = int'(ma) - int'(mb);
            ms = 4'((r + 16) % 16);
            mc = (int'(ma) >= int'(mb));
        end
    endtask

    task automatic check(input string name, input logic [3:0] se, input logic ce);
        checks++;
        if (s !== se || c_out !== ce) begin
            errors++;
            $display("FAIL %s: got s=%0d c_out=%b, expected s=%0d c_out=%b", name, s, c_out, se, ce);
        end
    endtask

    // Drive inputs away from the edge, then sample 1 time unit after the capturing edge.
    task automatic step(input logic [3:0] ta, input logic [3:0] tb, input logic tsub, input logic tcin);
        @(negedge clk);
        a = ta; b = tb; sub = tsub; c_in = tcin;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] se;
        logic       ce;

        vecs[0] = '{4'd3,  4'd2, 1'b0, 1'b0, 4'd5,  1'b0};
        vecs[1] = '{4'd7,  4'd8, 1'b0, 1'b0, 4'd15, 1'b0};
        vecs[2] = '{4'd15, 4'd1, 1'b0, 1'b0, 4'd0,  1'b1};
        vecs[3] = '{4'd5,  4'd3, 1'b1, 1'b0, 4'd2,  1'b1};
        vecs[4] = '{4'd8,  4'd8, 1'b1, 1'b0, 4'd0,  1'b1};
        vecs[5] = '{4'd3,  4'd5, 1'b1, 1'b0, 4'd14, 1'b0};
        vecs[6] = '{4'd15, 4'd1, 1'b0, 1'b1, 4'd0,  1'b1};

        a = 4'd0; b = 4'd0; sub = 1'b0; c_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset_at_start", 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        foreach (vecs[i]) begin
            step(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
            check($sformatf("vec%0d", i), vecs[i].s_exp, vecs[i].c_exp);
        end

        // Mid-cycle input change must not reach the outputs before the next edge.
        step(4'd3, 4'd2, 1'b0, 1'b0);
        check("midcycle_before", 4'd5, 1'b0);
        #2;
        a = 4'd15; b = 4'd1; sub = 1'b0; c_in = 1'b1;
        #2;
        check("midcycle_hold", 4'd5, 1'b0);
        @(posedge clk);
        #1;
        check("midcycle_next_edge", 4'd0, 1'b1);

        // Asynchronous reset mid-cycle, pending result discarded, clean release.
        step(4'd9, 4'd3, 1'b0, 1'b0);
        check("pre_reset", 4'd12, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 4'd0, 1'b0);
        a = 4'd14; b = 4'd7; sub = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold_edges", 4'd0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = 4'd9; b = 4'd4; sub = 1'b1; c_in = 1'b0;
        @(posedge clk);
        #1;
        check("first_after_release", 4'd5, 1'b1);

        // Exhaustive sweep of every (a, b, sub) combination.
        for (int sb = 0; sb < 2; sb++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    step(4'(ia), 4'(ib), 1'(sb), 1'b0);
                    model(4'(ia), 4'(ib), 1'(sb), se, ce);
                    check("sweep", se, ce);
                end
            end
        end

        // Random stimulus with c_in toggling freely.
        for (int n = 0; n < 200; n++) begin
            logic [3:0] ra, rb;
            logic       rs, rc;
            ra = 4'($urandom_range(15));
            rb = 4'($urandom_range(15));
            rs = 1'($urandom_range(1));
            rc = 1'($urandom_range(1));
            step(ra, rb, rs, rc);
            model(ra, rb, rs, se, ce);
            check("random", se, ce);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
